// File: rtl/ones_frame_acc_pkg.sv
// Shared constants and FSM encoding for the ones-count frame accumulator.
// Frame-dependent widths are derived where FRAME_LEN is known.
package ones_frame_acc_pkg;

  localparam int DATA_W = 6;
  localparam int PC_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ones_frame_acc_if.sv
// Word-in / frame-result-out handshake bundle for ones_frame_acc.
// The master is the word source plus result consumer; the slave is the accumulator.
interface ones_frame_acc_if #(
  parameter int FRAME_LEN = 8
);
  import ones_frame_acc_pkg::*;

  localparam int SUM_W = $clog2(DATA_W * FRAME_LEN + 1);
  localparam int LEN_W = $clog2(FRAME_LEN + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [PC_W-1:0]   out_max;
  logic [LEN_W-1:0]  out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_len
  );

endinterface

// File: rtl/ones_frame_acc_popcnt6.sv
// Combinational population count of one 6-bit word (result 0..6).
module popcnt6
  import ones_frame_acc_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [PC_W-1:0]   o_count
);

  // NOTE: combinational logic uses blocking '=' and assigns a default first, so the
  // loop accumulates in order and no latch is inferred.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_count = o_count + PC_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/ones_frame_acc.sv
// Accumulates popcounts of a word stream into frames of up to FRAME_LEN words and
// presents total ones, peak per-word count and word count once per frame.
module ones_frame_acc
  import ones_frame_acc_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  ones_frame_acc_if.slave bus
);

  localparam int SUM_W = $clog2(DATA_W * FRAME_LEN + 1);
  localparam int LEN_W = $clog2(FRAME_LEN + 1);

  state_t           r_state;
  state_t           w_next_state;

  logic [PC_W-1:0]  w_pc;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_close;
  logic             w_take;

  logic [SUM_W-1:0] r_acc_sum;
  logic [PC_W-1:0]  r_acc_max;
  logic [LEN_W-1:0] r_acc_len;
  logic [SUM_W-1:0] w_sum_nxt;
  logic [PC_W-1:0]  w_max_nxt;
  logic [LEN_W-1:0] w_len_nxt;

  logic [SUM_W-1:0] r_out_sum;
  logic [PC_W-1:0]  r_out_max;
  logic [LEN_W-1:0] r_out_len;

  popcnt6 u_popcnt6 (
    .i_data  (bus.in_data),
    .o_count (w_pc)
  );

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_take    = w_out_valid & bus.out_ready;
  assign w_sum_nxt = r_acc_sum + SUM_W'(w_pc);
  assign w_max_nxt = (w_pc > r_acc_max) ? w_pc : r_acc_max;
  assign w_len_nxt = r_acc_len + LEN_W'(1);
  // The frame closes on the word that reaches FRAME_LEN or carries in_last.
  assign w_close   = w_accept & ((w_len_nxt == LEN_W'(FRAME_LEN)) | bus.in_last);

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; reset is synchronous and clears all state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (w_close) begin
          w_next_state = ST_DONE;
        end else if (w_accept) begin
          w_next_state = ST_ACC;
        end
      end
      ST_DONE: begin
        if (w_take) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACC: w_in_ready  = !rst;
      ST_DONE:         w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulators hold the finished frame through DONE and clear on the handshake.
  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      r_acc_sum <= '0;
      r_acc_max <= '0;
      r_acc_len <= '0;
    end else if (w_accept) begin
      r_acc_sum <= w_sum_nxt;
      r_acc_max <= w_max_nxt;
      r_acc_len <= w_len_nxt;
    end
  end

  // Result registers are loaded only at close, so they read zero whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      r_out_sum <= '0;
      r_out_max <= '0;
      r_out_len <= '0;
    end else if (w_close) begin
      r_out_sum <= w_sum_nxt;
      r_out_max <= w_max_nxt;
      r_out_len <= w_len_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_max   = r_out_max;
  assign bus.out_len   = r_out_len;

endmodule
